// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap sequencer: FSM states, default
// datapath widths and the tap-index width helper.
package fir_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, WAIT} fir_state_e;

    localparam int COEF_W = 16;
    localparam int ACC_W  = 33;
    localparam int BANK_W = 8;

    // Bits needed to index num_taps taps; num_taps is a power of two >= 2.
    function automatic int tap_idx_w(input int num_taps);
        return $clog2(num_taps);
    endfunction

endpackage

// File: rtl/fir_watchdog.sv
// Counts cycles spent waiting for the dsp datapath and flags when the
// allowed number of WAIT cycles has been used up.
module fir_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // count_q holds the number of already-completed WAIT cycles, so expiry
    // coincides with the last permitted WAIT cycle.
    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequences the dsp multiply-accumulate datapath through every FIR tap per
// accepted sample, then returns the filtered result with a valid pulse.
module fir_tap_sequencer #(
    parameter int  NUM_TAPS = 4,
    parameter int  COEF_W   = fir_pkg::COEF_W,
    parameter int  ACC_W    = fir_pkg::ACC_W,
    parameter int  TIMEOUT  = 64,
    localparam int IDX_W    = fir_pkg::tap_idx_w(NUM_TAPS),
    localparam int ADDR_W   = fir_pkg::BANK_W + IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              signal_en,
    input  logic [7:0]        eqVal,
    output logic              win_en_o,
    output logic [ADDR_W-1:0] coef_addr_o,
    input  logic [COEF_W-1:0] coef_data_i,
    output logic              dsp_rst_o,
    output logic              clk_en_o,
    output logic [COEF_W-1:0] tap_o,
    output logic [7:0]        tapnum_o,
    input  logic [ACC_W-1:0]  dsp_result_i,
    input  logic              dsp_done_i,
    output logic [ACC_W-1:0]  result_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              timeout_o
);

    import fir_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    fir_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
    logic [7:0]        tapnum_q, tapnum_d;
    logic              dsp_rst_q, dsp_rst_d;
    logic              win_en_q, win_en_d;
    logic              clk_en_q, clk_en_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic [IDX_W-1:0]  idx_inc;
    logic              wd_expired;

    fir_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != WAIT),
        .enable  (state_q == WAIT),
        .expired (wd_expired)
    );

    assign idx_inc = idx_q + IDX_W'(1);

    // Outputs are computed for the state being entered, so every output is a
    // flop; the address always runs one tap ahead to cover the ROM latency.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        result_d    = result_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        dsp_rst_d   = 1'b0;
        win_en_d    = 1'b0;
        clk_en_d    = 1'b0;
        valid_d     = 1'b0;
        tapnum_d    = '0;
        coef_addr_d = '0;

        case (state_q)
            IDLE: begin
                if (signal_en) begin
                    state_d     = CLEAR;
                    bank_d      = eqVal;
                    idx_d       = '0;
                    dsp_rst_d   = 1'b1;
                    win_en_d    = 1'b1;
                    coef_addr_d = {eqVal, IDX_W'(0)};
                end
            end
            CLEAR: begin
                state_d     = ISSUE;
                idx_d       = '0;
                clk_en_d    = 1'b1;
                coef_addr_d = {bank_q, IDX_W'(1)};
            end
            ISSUE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = WAIT;
                    idx_d   = '0;
                end else begin
                    idx_d       = idx_inc;
                    clk_en_d    = 1'b1;
                    tapnum_d    = 8'(idx_inc);
                    coef_addr_d = {bank_q, idx_inc + IDX_W'(1)};
                end
            end
            WAIT: begin
                // A done arriving on the final permitted cycle still wins.
                if (dsp_done_i) begin
                    state_d  = IDLE;
                    result_d = dsp_result_i;
                    valid_d  = 1'b1;
                end else if (wd_expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (signal_en && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            bank_q      <= '0;
            result_q    <= '0;
            coef_addr_q <= '0;
            tapnum_q    <= '0;
            dsp_rst_q   <= 1'b0;
            win_en_q    <= 1'b0;
            clk_en_q    <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bank_q      <= bank_d;
            result_q    <= result_d;
            coef_addr_q <= coef_addr_d;
            tapnum_q    <= tapnum_d;
            dsp_rst_q   <= dsp_rst_d;
            win_en_q    <= win_en_d;
            clk_en_q    <= clk_en_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign win_en_o    = win_en_q;
    assign coef_addr_o = coef_addr_q;
    assign dsp_rst_o   = dsp_rst_q;
    assign clk_en_o    = clk_en_q;
    assign tap_o       = clk_en_q ? coef_data_i : '0;
    assign tapnum_o    = tapnum_q;
    assign result_o    = result_q;
    assign valid_o     = valid_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized self-checking bench for fir_tap_sequencer, compared against a
// sample-level timeline model kept here in the bench.
module tb_fir_tap_sequencer;

   localparam int NUM_TAPS = 4;
   localparam int COEF_W   = 16;
   localparam int ACC_W    = 33;
   localparam int TIMEOUT  = 64;
   localparam int ADDR_W   = 8 + $clog2(NUM_TAPS);

   logic              clk;
   logic              reset;
   logic              signal_en;
   logic [7:0]        eqVal;
   logic              win_en_o;
   logic [ADDR_W-1:0] coef_addr_o;
   logic [COEF_W-1:0] coef_data_i;
   logic              dsp_rst_o;
   logic              clk_en_o;
   logic [COEF_W-1:0] tap_o;
   logic [7:0]        tapnum_o;
   logic [ACC_W-1:0]  dsp_result_i;
   logic              dsp_done_i;
   logic [ACC_W-1:0]  result_o;
   logic              valid_o;
   logic              busy_o;
   logic              overrun_o;
   logic              timeout_o;

   int vecCount  = 0;
   int missCount = 0;

   // Reference model: a sample is described by how many cycles have passed
   // since it was accepted (mPhase); cycle 1 clears, the next NUM_TAPS cycles
   // issue taps, and the rest are spent waiting for the dsp.
   bit               mActive    = 0;
   int               mPhase     = 0;
   logic [7:0]       mBank      = 0;
   bit               mJustReset = 0;
   bit               expValid   = 0;
   bit               expOverrun = 0;
   bit               expTimeout = 0;
   logic [ACC_W-1:0] expResult  = 0;

   fir_tap_sequencer #(
      .NUM_TAPS (NUM_TAPS),
      .COEF_W   (COEF_W),
      .ACC_W    (ACC_W),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .signal_en    (signal_en),
      .eqVal        (eqVal),
      .win_en_o     (win_en_o),
      .coef_addr_o  (coef_addr_o),
      .coef_data_i  (coef_data_i),
      .dsp_rst_o    (dsp_rst_o),
      .clk_en_o     (clk_en_o),
      .tap_o        (tap_o),
      .tapnum_o     (tapnum_o),
      .dsp_result_i (dsp_result_i),
      .dsp_done_i   (dsp_done_i),
      .result_o     (result_o),
      .valid_o      (valid_o),
      .busy_o       (busy_o),
      .overrun_o    (overrun_o),
      .timeout_o    (timeout_o)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Coefficient ROM contents: bank 0xF4 holds the known {4,1,2,1} taps,
   // every other word is a scrambled function of bank and index.
   function automatic logic [COEF_W-1:0] romWord(input logic [ADDR_W-1:0] a);
      int bank;
      int idx;
      bank = int'(a) / NUM_TAPS;
      idx  = int'(a) % NUM_TAPS;
      if (bank == 'hF4) begin
         case (idx)
            0:       return 16'd4;
            1:       return 16'd1;
            2:       return 16'd2;
            default: return 16'd1;
         endcase
      end
      return 16'((bank * 977 + idx * 131 + 17) ^ (bank << 5));
   endfunction

   // Coefficient ROM with exactly one cycle of read latency.
   always @(posedge clk) begin
      coef_data_i <= romWord(coef_addr_o);
   end

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecCount++;
      if (obs !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit inWait();
      return mActive && (mPhase >= NUM_TAPS + 2);
   endfunction

   function automatic int waitIdx();
      return mPhase - (NUM_TAPS + 1);
   endfunction

   // Advances the model across one clock edge given the inputs sampled there.
   task automatic modelStep(input logic r, input logic se, input logic [7:0] eq,
                            input logic d, input logic [ACC_W-1:0] res);
      expValid   = 0;
      mJustReset = 0;
      if (r) begin
         mActive    = 0;
         mPhase     = 0;
         expResult  = '0;
         expOverrun = 0;
         expTimeout = 0;
         mJustReset = 1;
      end else if (mActive) begin
         if (se) expOverrun = 1;
         if (mPhase >= NUM_TAPS + 2) begin
            if (d) begin
               expResult = res;
               expValid  = 1;
               mActive   = 0;
            end else if (waitIdx() == TIMEOUT) begin
               expTimeout = 1;
               mActive    = 0;
            end else begin
               mPhase++;
            end
         end else begin
            mPhase++;
         end
      end else if (se) begin
         mActive = 1;
         mPhase  = 1;
         mBank   = eq;
      end
   endtask

   // Compares every DUT output against what the model says this cycle shows.
   task automatic checkAll();
      bit isClear;
      bit isIssue;
      int idx;
      isClear = mActive && (mPhase == 1);
      isIssue = mActive && (mPhase >= 2) && (mPhase <= NUM_TAPS + 1);
      checkOutput("busy",    64'(busy_o),    64'(mActive));
      checkOutput("dsp_rst", 64'(dsp_rst_o), 64'(isClear));
      checkOutput("win_en",  64'(win_en_o),  64'(isClear));
      checkOutput("clk_en",  64'(clk_en_o),  64'(isIssue));
      checkOutput("valid",   64'(valid_o),   64'(expValid));
      checkOutput("result",  64'(result_o),  64'(expResult));
      checkOutput("overrun", 64'(overrun_o), 64'(expOverrun));
      checkOutput("timeout", 64'(timeout_o), 64'(expTimeout));
      if (isClear) begin
         checkOutput("clear_addr", 64'(coef_addr_o), 64'(mBank * NUM_TAPS));
      end
      if (isIssue) begin
         idx = mPhase - 2;
         checkOutput("tapnum",     64'(tapnum_o),    64'(idx));
         checkOutput("tap",        64'(tap_o),       64'(romWord(ADDR_W'(mBank * NUM_TAPS + idx))));
         checkOutput("issue_addr", 64'(coef_addr_o), 64'(mBank * NUM_TAPS + (idx + 1) % NUM_TAPS));
      end
      if (mJustReset) begin
         checkOutput("rst_tap",    64'(tap_o),       64'd0);
         checkOutput("rst_tapnum", 64'(tapnum_o),    64'd0);
         checkOutput("rst_addr",   64'(coef_addr_o), 64'd0);
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, step the model on the
   // rising edge, and check outputs just after it.
   task automatic applyStimulus(input logic r, input logic se, input logic [7:0] eq,
                                input logic d, input logic [ACC_W-1:0] res);
      @(negedge clk);
      reset        = r;
      signal_en    = se;
      eqVal        = eq;
      dsp_done_i   = d;
      dsp_result_i = res;
      @(posedge clk);
      modelStep(r, se, eq, d, res);
      #1;
      checkAll();
   endtask

   function automatic logic [ACC_W-1:0] randResult();
      logic [ACC_W-1:0] v;
      v = {1'($urandom_range(0, 1)), $urandom()};
      return v;
   endfunction

   // Presents one sample and plays the dsp until the sample completes.
   // lat = WAIT cycle on which the dsp reports done (0 = never); extraPhase
   // re-pulses signal_en and rstPhase asserts reset at that phase (0 = off).
   task automatic runSample(input logic [7:0] eq, input int lat, input logic [ACC_W-1:0] res,
                            input int extraPhase, input int rstPhase, input bit noise);
      logic             r;
      logic             se;
      logic             d;
      logic [ACC_W-1:0] rv;
      applyStimulus(1'b0, 1'b1, eq, 1'b0, randResult());
      for (int c = 0; c < 200 && mActive; c++) begin
         r  = (rstPhase > 0) && (mPhase == rstPhase);
         se = (extraPhase > 0) && (mPhase == extraPhase);
         d  = inWait() && (waitIdx() == lat);
         if (noise && !inWait()) d = 1'($urandom_range(0, 1));
         rv = d && inWait() ? res : randResult();
         applyStimulus(r, se, 8'($urandom()), d, rv);
      end
      if (mActive) begin
         missCount++;
         $display("[TB] FAIL sample_bound: model still busy after 200 cycles");
      end
   endtask

   // Directed scenarios first, then a randomized soak with back-to-back
   // samples, idle gaps, stray done pulses and occasional overruns.
   initial begin
      reset        = 1'b1;
      signal_en    = 1'b0;
      eqVal        = 8'h00;
      dsp_done_i   = 1'b0;
      dsp_result_i = '0;

      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, '0);
      applyStimulus(1'b1, 1'b1, 8'hAA, 1'b1, 33'h1);

      runSample(8'hF4, 2, 33'h1E, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 33'h77);

      runSample(8'h37, 3, 33'h1_2345_6789, 3, 0, 0);
      runSample(8'h5C, 0, 33'h0, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, '0);

      runSample(8'h22, 2, 33'h55, 3, 4, 0);
      runSample(8'h01, 1, 33'h1ABCD, 0, 0, 0);
      runSample(8'h02, 4, 33'h0_FEED_BEEF, 0, 0, 1);

      for (int s = 0; s < 25; s++) begin
         int gap;
         int extra;
         gap   = $urandom_range(0, 2);
         extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NUM_TAPS + 4) : 0;
         for (int g = 0; g < gap; g++) begin
            applyStimulus(1'b0, 1'b0, 8'($urandom()), 1'($urandom_range(0, 1)), randResult());
         end
         runSample(8'($urandom()), $urandom_range(1, 10), randResult(), extra, 0, 1);
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
